ls_store_buffer: RTL and testbench

Parametrised post-commit store buffer for the load/store stage. It replaces single-entry "last store" forwarding with a DEPTH-entry FIFO of doubleword-aligned, byte-masked stores. Stores are accepted from the L/S stage and drained in order to data memory over a valid/ready port. Loads are served by byte-granular youngest-first forwarding from all pending entries, with optional coalescing into the youngest entry.

---
 rtl/ls_store_buffer_pkg.sv | 43 ++++
 rtl/ls_store_buffer_if.sv | 42 ++++
 rtl/ls_store_buffer_align.sv | 26 ++
 rtl/ls_store_buffer.sv | 118 +++++++++++
 tb/tb_ls_store_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ls_store_buffer_pkg.sv
// Shared types and helpers for the post-commit store buffer: memop codes,
// byte-lane mask generation and the buffer entry record.
package ls_store_buffer_pkg;

  localparam logic [2:0] MEMOP_SB  = 3'b000;
  localparam logic [2:0] MEMOP_SH  = 3'b001;
  localparam logic [2:0] MEMOP_SW  = 3'b010;
  localparam logic [2:0] MEMOP_SD  = 3'b011;
  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LD  = 3'b011;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;
  localparam logic [2:0] MEMOP_LWU = 3'b110;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } sb_entry_t;

  // Bit 2 only selects load sign handling, so it never changes the size.
  function automatic logic [7:0] size_mask(input logic [2:0] memop, input logic [2:0] off);
    logic [15:0] m;
    case (memop)
      3'b000, 3'b100: m = 16'h0001;
      3'b001, 3'b101: m = 16'h0003;
      3'b010, 3'b110: m = 16'h000F;
      default:        m = 16'h00FF;
    endcase
    m = m << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] byte_expand(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

endpackage

// File: rtl/ls_store_buffer_if.sv
// Store-request, load-lookup and memory-write ports of the store buffer.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid never waits on ready, and a presented write holds still until it transfers.
interface ls_store_buffer_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  logic                     st_valid_i;
  logic                     st_ready_o;
  logic [XLEN-1:0]          st_addr_i;
  logic [XLEN-1:0]          st_data_i;
  logic [2:0]               st_memop_i;
  logic                     st_misalign_o;
  logic                     ld_valid_i;
  logic [XLEN-1:0]          ld_addr_i;
  logic [2:0]               ld_memop_i;
  logic [XLEN-1:0]          fwd_data_o;
  logic [7:0]               fwd_mask_o;
  logic                     fwd_full_o;
  logic                     ld_stall_o;
  logic                     mem_wvalid_o;
  logic                     mem_wready_i;
  logic [XLEN-1:0]          mem_waddr_o;
  logic [XLEN-1:0]          mem_wdata_o;
  logic [7:0]               mem_wmask_o;
  logic                     empty_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_memop_i,
    input  ld_valid_i, ld_addr_i, ld_memop_i, mem_wready_i,
    output st_ready_o, st_misalign_o, fwd_data_o, fwd_mask_o, fwd_full_o, ld_stall_o,
    output mem_wvalid_o, mem_waddr_o, mem_wdata_o, mem_wmask_o, empty_o, count_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_memop_i,
    output ld_valid_i, ld_addr_i, ld_memop_i, mem_wready_i,
    input  st_ready_o, st_misalign_o, fwd_data_o, fwd_mask_o, fwd_full_o, ld_stall_o,
    input  mem_wvalid_o, mem_waddr_o, mem_wdata_o, mem_wmask_o, empty_o, count_o
  );
endinterface

// File: rtl/ls_store_buffer_align.sv
// Places a right-justified access into its dword byte lanes and flags
// accesses that are not naturally aligned.
module ls_store_align
  import ls_store_buffer_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [2:0]  off,
  input  logic [63:0] data,
  output logic [63:0] lane_data,
  output logic [7:0]  mask,
  output logic        misalign
);

  always_comb begin
    mask      = size_mask(memop, off);
    // Bytes outside the mask are zeroed so entries never carry stale lanes.
    lane_data = (data << {off, 3'b000}) & byte_expand(mask);
    case (memop[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = off[0];
      2'd2:    misalign = (off[1:0] != 2'd0);
      default: misalign = (off != 3'd0);
    endcase
  end

endmodule

// File: rtl/ls_store_buffer.sv
// DEPTH-entry in-order store buffer of dword-aligned byte-masked stores with
// youngest-first byte forwarding to loads and optional coalescing.
module ls_store_buffer
  import ls_store_buffer_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input logic              clk,
  input logic              rst_n,
  ls_store_buffer_if.slave sb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t       ent [DEPTH];
  logic [PW-1:0]   head, tail, young, fi;
  logic [CW-1:0]   count;
  logic [63:0]     st_lane, ld_lane, merged;
  logic [7:0]      st_mask, ld_raw, req_mask, cov, fmask;
  logic            st_mis, ld_mis, full, empty, pop, coal_hit, st_ready;
  logic            accept, enq, coal, fwd_full;
  logic [XLEN-1:0] st_dword, ld_dword;

  ls_store_align u_st_align (
    .memop(sb.st_memop_i), .off(sb.st_addr_i[2:0]), .data(sb.st_data_i),
    .lane_data(st_lane), .mask(st_mask), .misalign(st_mis)
  );

  // Feeding all-ones turns the lane output into the byte-expanded request mask.
  ls_store_align u_ld_align (
    .memop(sb.ld_memop_i), .off(sb.ld_addr_i[2:0]), .data('1),
    .lane_data(ld_lane), .mask(ld_raw), .misalign(ld_mis)
  );

  assign st_dword = {sb.st_addr_i[XLEN-1:3], 3'b000};
  assign ld_dword = {sb.ld_addr_i[XLEN-1:3], 3'b000};
  assign young    = tail - 1'b1;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop      = !empty && sb.mem_wready_i;

  // count >= 2 keeps the youngest entry distinct from the head being presented.
  assign coal_hit = (COALESCE != 0) && sb.st_valid_i && !st_mis &&
                    (count >= CW'(2)) && (ent[young].addr == st_dword);
  assign st_ready = !full || pop || coal_hit;
  assign accept   = sb.st_valid_i && st_ready && !st_mis;
  assign enq      = accept && !coal_hit;
  assign coal     = accept && coal_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      // When full, head == tail: this write must land after the pop clear.
      if (enq) begin
        ent[tail] <= '{valid: 1'b1, addr: st_dword, data: st_lane, mask: st_mask};
        tail      <= tail + 1'b1;
      end
      if (coal) begin
        ent[young].data <= (ent[young].data & ~byte_expand(st_mask)) | st_lane;
        ent[young].mask <= ent[young].mask | st_mask;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Walking oldest to youngest lets younger bytes overwrite older ones.
  always_comb begin
    cov    = '0;
    merged = '0;
    fi     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fi = head + PW'(i);
      if (ent[fi].valid && (ent[fi].addr == ld_dword)) begin
        for (int b = 0; b < 8; b++) begin
          if (ent[fi].mask[b]) begin
            cov[b]         = 1'b1;
            merged[8*b +: 8] = ent[fi].data[8*b +: 8];
          end
        end
      end
    end
  end

  assign req_mask = ld_mis ? 8'h00 : ld_raw;
  assign fmask    = cov & req_mask;
  assign fwd_full = sb.ld_valid_i && (req_mask != 8'h00) && ((req_mask & ~fmask) == 8'h00);

  assign sb.fwd_mask_o    = sb.ld_valid_i ? fmask : 8'h00;
  assign sb.fwd_data_o    = (sb.ld_valid_i && !ld_mis) ? (merged & ld_lane) : '0;
  assign sb.fwd_full_o    = fwd_full;
  assign sb.ld_stall_o    = sb.ld_valid_i && (fmask != 8'h00) && !fwd_full;

  assign sb.st_ready_o    = st_ready;
  assign sb.st_misalign_o = sb.st_valid_i && st_mis;

  assign sb.mem_wvalid_o  = !empty;
  assign sb.mem_waddr_o   = empty ? '0 : ent[head].addr;
  assign sb.mem_wdata_o   = empty ? '0 : ent[head].data;
  assign sb.mem_wmask_o   = empty ? 8'h00 : ent[head].mask;
  assign sb.empty_o       = empty;
  assign sb.count_o       = count;

endmodule

// File: tb/tb_ls_store_buffer.sv
// Randomized and directed bench for ls_store_buffer against a queue-based
// reference model of pending stores.
module tb_ls_store_buffer;
  import ls_store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ls_store_buffer_if #(.XLEN(64), .DEPTH(DEPTH)) sbif ();

  ls_store_buffer #(.XLEN(64), .DEPTH(DEPTH), .COALESCE(1)) dut (
    .clk(clk), .rst_n(rst_n), .sb(sbif)
  );

  // Pending stores, oldest first: {dword addr, lane data, byte mask}.
  logic [135:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int m_size(input logic [2:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic bit m_mis(input logic [2:0] op, input logic [63:0] a);
    return (int'(a[2:0]) % m_size(op)) != 0;
  endfunction

  function automatic logic [7:0] m_mask(input logic [2:0] op, input logic [63:0] a);
    logic [7:0] m;
    int off;
    m = '0;
    off = int'(a[2:0]);
    for (int b = 0; b < 8; b++) if (b >= off && b < off + m_size(op)) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_lane(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] r;
    int off;
    r = '0;
    off = int'(a[2:0]);
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + m_size(op)) r[8*b +: 8] = d[8*(b-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] dword(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

  function automatic bit m_hit();
    logic [135:0] y;
    if (!sbif.st_valid_i || m_mis(sbif.st_memop_i, sbif.st_addr_i) || exp_q.size() < 2) return 1'b0;
    y = exp_q[exp_q.size()-1];
    return y[135:72] == dword(sbif.st_addr_i);
  endfunction

  task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd, input logic [2:0] sm,
                       input logic lv, input logic [63:0] la, input logic [2:0] lm, input logic wr);
    sbif.st_valid_i   = sv;
    sbif.st_addr_i    = sa;
    sbif.st_data_i    = sd;
    sbif.st_memop_i   = sm;
    sbif.ld_valid_i   = lv;
    sbif.ld_addr_i    = la;
    sbif.ld_memop_i   = lm;
    sbif.mem_wready_i = wr;
    #1;
  endtask

  task automatic cmp_model();
    int n;
    bit pop;
    logic [135:0] e;
    logic [7:0] req, fm;
    logic [63:0] fd;
    bit found, full;
    n   = exp_q.size();
    pop = (n > 0) && sbif.mem_wready_i;
    check("st_misalign", sbif.st_misalign_o, sbif.st_valid_i && m_mis(sbif.st_memop_i, sbif.st_addr_i));
    check("st_ready", sbif.st_ready_o, (n < DEPTH) || pop || m_hit());
    check("count", sbif.count_o, n);
    check("empty", sbif.empty_o, n == 0);
    check("mem_wvalid", sbif.mem_wvalid_o, n > 0);
    if (n > 0) begin
      e = exp_q[0];
      check("mem_waddr", sbif.mem_waddr_o, e[135:72]);
      check("mem_wdata", sbif.mem_wdata_o, e[71:8]);
      check("mem_wmask", sbif.mem_wmask_o, e[7:0]);
    end
    req = sbif.ld_valid_i ? m_mask(sbif.ld_memop_i, sbif.ld_addr_i) : 8'h00;
    fm  = '0;
    fd  = '0;
    for (int b = 0; b < 8; b++) begin
      found = 1'b0;
      for (int k = n - 1; k >= 0; k--) begin
        e = exp_q[k];
        if (req[b] && !found && e[135:72] == dword(sbif.ld_addr_i) && e[b]) begin
          found = 1'b1;
          fm[b] = 1'b1;
          fd[8*b +: 8] = e[8+8*b +: 8];
        end
      end
    end
    full = (req != 0) && ((req & ~fm) == 0);
    check("fwd_mask", sbif.fwd_mask_o, fm);
    check("fwd_data", sbif.fwd_data_o, fd);
    check("fwd_full", sbif.fwd_full_o, full);
    check("ld_stall", sbif.ld_stall_o, ((fm & req) != 0) && !full);
  endtask

  task automatic tick();
    int n;
    bit pop, mis, hit, acc;
    logic [63:0] lane, dw;
    logic [7:0] msk;
    logic [135:0] y;
    n    = exp_q.size();
    pop  = (n > 0) && sbif.mem_wready_i;
    mis  = m_mis(sbif.st_memop_i, sbif.st_addr_i);
    hit  = m_hit();
    acc  = sbif.st_valid_i && ((n < DEPTH) || pop || hit) && !mis;
    lane = m_lane(sbif.st_memop_i, sbif.st_addr_i, sbif.st_data_i);
    msk  = m_mask(sbif.st_memop_i, sbif.st_addr_i);
    dw   = dword(sbif.st_addr_i);
    @(posedge clk);
    if (acc && hit) begin
      y = exp_q[n-1];
      for (int b = 0; b < 8; b++) if (msk[b]) y[8+8*b +: 8] = lane[8*b +: 8];
      y[7:0] = y[7:0] | msk;
      exp_q[n-1] = y;
    end
    if (pop) void'(exp_q.pop_front());
    if (acc && !hit) exp_q.push_back({dw, lane, msk});
    @(negedge clk);
  endtask

  task automatic cyc(input logic sv, input logic [63:0] sa, input logic [63:0] sd, input logic [2:0] sm,
                     input logic lv, input logic [63:0] la, input logic [2:0] lm, input logic wr);
    drive(sv, sa, sd, sm, lv, la, lm, wr);
    cmp_model();
    tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 4 * DEPTH) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      g++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("drain_count", sbif.count_o, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_count", sbif.count_o, 0);
    check("rst_wvalid", sbif.mem_wvalid_o, 0);
    check("rst_st_ready", sbif.st_ready_o, 1);
    check("rst_empty", sbif.empty_o, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] sa, la, sd;
    logic [2:0]  sm, lm;
    int          sz;

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_waddr", sbif.mem_waddr_o, 0);
    check("rst_wdata", sbif.mem_wdata_o, 0);
    check("rst_wmask", sbif.mem_wmask_o, 0);

    // Full-dword store, then an upper-word load fully covered by it.
    cyc(1, 64'h8000_0008, 64'h1122_3344_5566_7788, MEMOP_SD, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 64'h8000_000C, MEMOP_LW, 0);
    cmp_model();
    check("sd_fwd_full", sbif.fwd_full_o, 1);
    check("sd_fwd_mask", sbif.fwd_mask_o, 64'hF0);
    check("sd_fwd_hi", sbif.fwd_data_o[63:32], 64'h1122_3344);
    tick();
    drain();

    // Two byte stores to one dword: the second sits behind the head.
    cyc(1, 64'h100, 64'hAA, MEMOP_SB, 0, 0, 0, 0);
    cyc(1, 64'h100, 64'hBB, MEMOP_SB, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cmp_model();
    check("sb_count", sbif.count_o, 2);
    check("sb_wvalid", sbif.mem_wvalid_o, 1);
    tick();
    cyc(1, 64'h101, 64'hCC, MEMOP_SB, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("coal_count", sbif.count_o, 2);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cmp_model();
    check("sb_last_byte", sbif.mem_wdata_o[7:0], 64'hBB);
    check("sb_last_mask", sbif.mem_wmask_o, 64'h03);
    tick();
    drain();

    // Partial coverage stalls the load until the drain retires the store.
    cyc(1, 64'h200, 64'h1234, MEMOP_SH, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 64'h200, MEMOP_LW, 0);
    cmp_model();
    check("part_stall", sbif.ld_stall_o, 1);
    check("part_full", sbif.fwd_full_o, 0);
    tick();
    cyc(0, 0, 0, 0, 1, 64'h200, MEMOP_LW, 1);
    drive(0, 0, 0, 0, 1, 64'h200, MEMOP_LW, 0);
    cmp_model();
    check("part_stall_clr", sbif.ld_stall_o, 0);
    tick();

    // Fill, then store and drain in the same cycle while full.
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 64'h400 + 64'(8*i), {$urandom, $urandom}, MEMOP_SD, 0, 0, 0, 0);
    drive(1, 64'h420, 64'h5555, MEMOP_SD, 0, 0, 0, 0);
    cmp_model();
    check("full_ready", sbif.st_ready_o, 0);
    tick();
    drive(1, 64'h420, 64'h5555, MEMOP_SD, 0, 0, 0, 1);
    cmp_model();
    check("full_pop_ready", sbif.st_ready_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("full_pop_count", sbif.count_o, 4);
    drain();

    // Misaligned word store is acknowledged and dropped.
    drive(1, 64'h302, 64'hDEAD_BEEF, MEMOP_SW, 0, 0, 0, 0);
    cmp_model();
    check("mis_flag", sbif.st_misalign_o, 1);
    check("mis_ready", sbif.st_ready_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("mis_count", sbif.count_o, 0);
    check("mis_wvalid", sbif.mem_wvalid_o, 0);

    // Reset in the middle of a burst drops everything at once.
    cyc(1, 64'h500, 64'h11, MEMOP_SB, 0, 0, 0, 0);
    cyc(1, 64'h508, 64'h22, MEMOP_SB, 0, 0, 0, 0);
    drive(1, 64'h510, 64'h33, MEMOP_SB, 0, 0, 0, 1);
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      sm = 3'($urandom_range(0, 3));
      sz = m_size(sm);
      sa = 64'h1000 + 64'(8 * $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) sa[2:0] = 3'($urandom_range(0, 7));
      else sa[2:0] = 3'($urandom_range(0, 8 / sz - 1) * sz);
      sd = {$urandom, $urandom};
      lm = 3'($urandom_range(0, 6));
      if (lm == 3'b011) lm = MEMOP_LD;
      sz = m_size(lm);
      la = 64'h1000 + 64'(8 * $urandom_range(0, 5));
      la[2:0] = 3'($urandom_range(0, 8 / sz - 1) * sz);
      cyc(1'($urandom_range(0, 9) < 7), sa, sd, sm,
          1'($urandom_range(0, 1)), la, lm, 1'($urandom_range(0, 9) < 4));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
